// File: rtl/fetch_pkg.sv
// Shared constants and opcode decode helpers for the instruction fetch unit.
// Used by instr_fetch_unit and call_stack.
package fetch_pkg;

    localparam int DEF_ADDR_W      = 11;
    localparam int DEF_INSTR_W     = 14;
    localparam int DEF_STACK_DEPTH = 8;

    localparam logic [DEF_INSTR_W-1:0] NOP        = 14'h0000;
    localparam logic [DEF_INSTR_W-1:0] OP_RETURN  = 14'h0008;
    localparam logic [DEF_INSTR_W-1:0] OP_RETFIE  = 14'h0009;

    localparam logic [DEF_INSTR_W-1:0] GOTO_MASK  = 14'h3800;
    localparam logic [DEF_INSTR_W-1:0] GOTO_VAL   = 14'h2800;
    localparam logic [DEF_INSTR_W-1:0] CALL_MASK  = 14'h3800;
    localparam logic [DEF_INSTR_W-1:0] CALL_VAL   = 14'h2000;
    localparam logic [DEF_INSTR_W-1:0] RETLW_MASK = 14'h3C00;
    localparam logic [DEF_INSTR_W-1:0] RETLW_VAL  = 14'h3400;

    function automatic logic is_goto(input logic [DEF_INSTR_W-1:0] instr);
        return (instr & GOTO_MASK) == GOTO_VAL;
    endfunction

    function automatic logic is_call(input logic [DEF_INSTR_W-1:0] instr);
        return (instr & CALL_MASK) == CALL_VAL;
    endfunction

    // RETURN, RETFIE and RETLW all pop the call stack the same way.
    function automatic logic is_ret(input logic [DEF_INSTR_W-1:0] instr);
        return (instr == OP_RETURN) || (instr == OP_RETFIE) ||
               ((instr & RETLW_MASK) == RETLW_VAL);
    endfunction

endpackage

// File: rtl/call_stack.sv
// Circular LIFO of return addresses; the stack pointer wraps modulo DEPTH.
// Sticky overflow/underflow flags are built only when STACK_ERR_EN is defined.
module call_stack
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top_data,
    output logic              ovf,
    output logic              unf
);

    localparam int SP_W = $clog2(DEPTH);

    logic [SP_W-1:0]   sp_q, sp_d;
    logic [ADDR_W-1:0] stack_q [DEPTH];
    logic [ADDR_W-1:0] stack_d [DEPTH];

    always_comb begin
        sp_d    = sp_q;
        stack_d = stack_q;
        if (push) begin
            stack_d[sp_q] = push_data;
            sp_d          = sp_q + SP_W'(1);
        end else if (pop) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    assign top_data = stack_q[sp_q - SP_W'(1)];

    always_ff @(posedge clk) begin
        if (rst) sp_q <= '0;
        else     sp_q <= sp_d;
    end

    // Stack contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

`ifdef STACK_ERR_EN
    logic [SP_W:0] depth_q, depth_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;

    always_comb begin
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (push) begin
            if (depth_q == (SP_W+1)'(DEPTH)) ovf_d   = 1'b1;
            else                             depth_d = depth_q + (SP_W+1)'(1);
        end else if (pop) begin
            if (depth_q == '0) unf_d   = 1'b1;
            else               depth_d = depth_q - (SP_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`else
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives the ROM address, registers the returned word and resolves GOTO/CALL/RETURN-class and skip.
// Define STACK_ERR_EN to enable the sticky stk_ovf/stk_unf call-stack error flags.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int INSTR_W     = DEF_INSTR_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               stall,
    input  logic               skip_in,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               stk_ovf,
    output logic               stk_unf
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               ir_valid_q, ir_valid_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               push, pop;
    logic [ADDR_W-1:0]  ret_addr;

    call_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_q),
        .top_data  (ret_addr),
        .ovf       (stk_ovf),
        .unf       (stk_unf)
    );

    // Control flow in ir replaces the word being fetched with a bubble.
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        ir_pc_d    = ir_pc_q;
        push       = 1'b0;
        pop        = 1'b0;
        if (!stall) begin
            if (ir_valid_q && is_goto(ir_q)) begin
                pc_d       = ir_q[ADDR_W-1:0];
                ir_d       = NOP;
                ir_valid_d = 1'b0;
            end else if (ir_valid_q && is_call(ir_q)) begin
                push       = 1'b1;
                pc_d       = ir_q[ADDR_W-1:0];
                ir_d       = NOP;
                ir_valid_d = 1'b0;
            end else if (ir_valid_q && is_ret(ir_q)) begin
                pop        = 1'b1;
                pc_d       = ret_addr;
                ir_d       = NOP;
                ir_valid_d = 1'b0;
            end else if (ir_valid_q && skip_in) begin
                pc_d       = pc_q + ADDR_W'(1);
                ir_d       = NOP;
                ir_valid_d = 1'b0;
            end else begin
                ir_d       = rom_data;
                ir_valid_d = 1'b1;
                ir_pc_d    = pc_q;
                pc_d       = pc_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            ir_q       <= NOP;
            ir_valid_q <= 1'b0;
            ir_pc_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            ir_pc_q    <= ir_pc_d;
        end
    end

    assign rom_addr = pc_q;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign ir_pc    = ir_pc_q;

endmodule
